// File: rtl/countdown_timer_bcd.sv
// MM:SS BCD countdown timer for the seven-segment display mux.
// The 250 ms slow clock from the divider is synchronized into clk_100mhz and
// edge-detected to form a tick; TICKS_PER_SEC ticks decrement one second.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | stopped; load latches a new time, start runs if time != 0
// ST_RUN   | counting down on ticks; pause suspends, load is ignored
// ST_PAUSE | time and prescaler frozen; start resumes, load returns to IDLE
// ST_DONE  | reached 00:00; alarm follows slow_clk, load returns to IDLE
module countdown_timer_bcd #(
    parameter int TICKS_PER_SEC = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic       slow_clk,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] disp_min,
    output logic [7:0] disp_sec,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] PRE_MAX = 8'(TICKS_PER_SEC - 1);

    state_t                 state;
    logic [7:0]             prescaler;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   slow_sync;
    logic                   tick;
    logic [15:0]            dec_val;
    logic                   dec_zero;
    logic                   time_zero;
    logic                   last_tick;
    logic [7:0]             san_min;
    logic [7:0]             san_sec;

    // Clamp each digit to 9, seconds tens to 5.
    function automatic logic [7:0] sanitize(input logic [7:0] val, input logic [3:0] tens_max);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = (val[7:4] > tens_max) ? tens_max : val[7:4];
        ones = (val[3:0] > 4'd9) ? 4'd9 : val[3:0];
        return {tens, ones};
    endfunction

    // Subtract one second from a non-zero MM:SS value with BCD borrows.
    function automatic logic [15:0] bcd_dec(input logic [7:0] mins, input logic [7:0] secs);
        logic [3:0] m_tens;
        logic [3:0] m_ones;
        logic [3:0] s_tens;
        logic [3:0] s_ones;
        {m_tens, m_ones} = mins;
        {s_tens, s_ones} = secs;
        if (s_ones != 4'd0) begin
            s_ones = s_ones - 4'd1;
        end else if (s_tens != 4'd0) begin
            s_ones = 4'd9;
            s_tens = s_tens - 4'd1;
        end else begin
            s_ones = 4'd9;
            s_tens = 4'd5;
            if (m_ones != 4'd0) begin
                m_ones = m_ones - 4'd1;
            end else begin
                m_ones = 4'd9;
                m_tens = m_tens - 4'd1;
            end
        end
        return {m_tens, m_ones, s_tens, s_ones};
    endfunction

    // Bring slow_clk into the clk_100mhz domain and keep one history bit for edge detection.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign slow_sync = sync_q[SYNC_STAGES-1];
    assign tick      = slow_sync & ~hist_q;

    assign dec_val   = bcd_dec(disp_min, disp_sec);
    assign dec_zero  = (dec_val == 16'h0000);
    assign time_zero = (disp_min == 8'h00) && (disp_sec == 8'h00);
    assign last_tick = tick && (prescaler == PRE_MAX);
    assign san_min   = sanitize(load_min, 4'd9);
    assign san_sec   = sanitize(load_sec, 4'd5);

    // Control FSM: strobes resolve as load > start > pause; all outputs registered here.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state     <= ST_IDLE;
            prescaler <= 8'd0;
            disp_min  <= 8'h00;
            disp_sec  <= 8'h00;
            running   <= 1'b0;
            done      <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            done  <= 1'b0;
            alarm <= 1'b0;
            case (state)
                ST_IDLE: begin
                    running <= 1'b0;
                    if (load) begin
                        disp_min  <= san_min;
                        disp_sec  <= san_sec;
                        prescaler <= 8'd0;
                    end else if (start && !time_zero) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    running <= 1'b1;
                    if (tick) begin
                        if (prescaler == PRE_MAX) begin
                            prescaler <= 8'd0;
                            disp_min  <= dec_val[15:8];
                            disp_sec  <= dec_val[7:0];
                            if (dec_zero) begin
                                state   <= ST_DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + 8'd1;
                        end
                    end
                    // A tick landing with pause is still counted; reaching zero wins over pause.
                    if (!load && !start && pause && !(last_tick && dec_zero)) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    running <= 1'b0;
                    if (load) begin
                        disp_min  <= san_min;
                        disp_sec  <= san_sec;
                        prescaler <= 8'd0;
                        state     <= ST_IDLE;
                    end else if (start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_DONE: begin
                    running <= 1'b0;
                    if (load) begin
                        disp_min  <= san_min;
                        disp_sec  <= san_sec;
                        prescaler <= 8'd0;
                        state     <= ST_IDLE;
                    end else begin
                        alarm <= slow_sync;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- MM:SS BCD countdown timer. Consumes the slow square wave from the 250 ms clock divider (rising edge every 250 ms) as a tick source. Four ticks make one second.
- Runs entirely in the 100 MHz domain. The slow clock is treated as data: it is synchronized and edge-detected, never used as a clock.
- Drives the seven-segment display mux (disp_min/disp_sec) and an LED alarm.

Parameters:
- TICKS_PER_SEC, 4: slow_clk rising edges per decremented second; legal range 1..255.
- SYNC_STAGES, 2: synchronizer flops on slow_clk; legal range 2..3.

Ports:
- clk_100mhz  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- slow_clk  input  1  250 ms square wave from the divider; asynchronous to this block's sampling.
- load  input  1  one-cycle strobe; latch load_min/load_sec.
- load_min  input  8  BCD minutes {tens, ones}.
- load_sec  input  8  BCD seconds {tens, ones}.
- start  input  1  one-cycle strobe; start or resume.
- pause  input  1  one-cycle strobe; pause.
- disp_min  output  8  current minutes, BCD.
- disp_sec  output  8  current seconds, BCD.
- running  output  1  high in RUN.
- done  output  1  one-cycle pulse when the count reaches 00:00.
- alarm  output  1  blinking indicator while in DONE.

Behaviour:
- Clocking and reset
  - Single clock: clk_100mhz. Synchronous, active-high reset: rst.
  - On reset: state=IDLE; disp_min=8'h00, disp_sec=8'h00; running=0, done=0, alarm=0; prescaler=0; synchronizer and edge flops=0.
- Tick detection
  - slow_clk passes through SYNC_STAGES flops, then one history flop.
  - tick = last sync stage & ~history.
  - With SYNC_STAGES=2, a slow_clk rise sampled at clk edge k gives tick high in the cycle after edge k+1. Registers update at edge k+2.
- States
  - IDLE
    - load: latch values and stay in IDLE.
    - start with time != 00:00: go to RUN.
    - start at 00:00: ignored.
  - RUN
    - On tick: if prescaler == TICKS_PER_SEC-1, then prescaler=0 and time decrements by one second; else prescaler+1.
    - pause: go to PAUSE.
    - load: ignored.
  - PAUSE
    - Prescaler and time are held.
    - start: return to RUN with the prescaler unchanged.
    - load: latch values, prescaler=0, go to IDLE.
  - DONE
    - alarm = synchronized slow_clk level.
    - load: latch values, go to IDLE.
    - start and pause: ignored.
- Strobe priority in the same cycle: load > start > pause. A tick coinciding with pause in RUN is still counted.
- BCD decrement: seconds are taken first, then minutes.
  - sec ones 0 → 9 with sec tens-1.
  - sec 00 → 59 with minutes-1.
  - min ones 0 → 9 with min tens-1.
- Arrival at zero: a decrement that produces 00:00 moves to DONE. done pulses high for exactly that one cycle, aligned with the disp update. The prescaler clears.
- Load sanitization: each digit >9 is clamped to 9; sec tens >5 is clamped to 5. Example: 8'hAF / 8'h7C loads as 99:59.
- Output timing
  - All outputs are registered.
  - running mirrors state==RUN from the cycle after the transition.
  - alarm is 0 outside DONE.
- Reset mid-operation: in any state, rst returns to IDLE and 00:00 on the next edge. No done pulse is generated.

Test Plan:
- Reset and basic countdown: reset; load 00:03, start; apply 12 slow_clk rises. Required:
  - disp_sec steps 03→02→01→00 on rises 4, 8 and 12, each visible 3 clk edges after the rise.
  - done pulses exactly once; state DONE; running=0.
- Borrow chain: load 10:00, start; 4 rises. Required: 09:59. Then load is ignored while running (apply load 05:05 → display remains 09:59).
- Pause/resume with prescaler retention: load 00:10, start; 2 rises; pause; 10 rises. Required: display 00:10 held. Then start; 2 rises. Required: 00:09.
- Edge cases:
  - start at 00:00 → stays IDLE, running=0.
  - load 8'hAF/8'h7C → displays 99:59.
  - load and start asserted in the same cycle in IDLE → values latched, state IDLE.
- Alarm and exit from DONE: reach DONE from 00:01. Required: alarm toggles in step with slow_clk, delayed by the sync latency. Then load 00:05 → IDLE, alarm=0, display 00:05.
- Reset mid-run: load 02:30, start, 6 rises; assert rst one cycle. Required: 00:00, IDLE, no done pulse. Also: slow_clk held high constantly produces no further ticks.
